// File: rtl/nn_pkg.sv
// Shared types for the neuron-layer datapath: activation modes and
// the activation sequencer FSM states, plus a small sizing helper.
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_IDENTITY = 2'd0,
        ACT_RELU     = 2'd1,
        ACT_LEAKY    = 2'd2,
        ACT_CLIP     = 2'd3
    } act_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } act_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/activation_unit.sv
// Combinational activation for one signed fixed-point element.
// Ports: x (element in), mode (activation select), y (element out).
module activation_unit
    import nn_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               LEAK_SHIFT = 3,
    parameter logic [WIDTH-1:0] CLIP_MAX   = WIDTH'(32'h0001_0000)
) (
    input  logic [WIDTH-1:0] x,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y
);

    logic             neg;
    logic             over;
    logic [WIDTH-1:0] leak;

    assign neg  = x[WIDTH-1];
    assign over = $signed(x) > $signed(CLIP_MAX);
    // arithmetic shift floors toward -inf and cannot overflow
    assign leak = WIDTH'($signed(x) >>> LEAK_SHIFT);

    always_comb begin
        y = x;
        unique case (act_mode_e'(mode))
            ACT_IDENTITY: y = x;
            ACT_RELU:     y = neg ? '0 : x;
            ACT_LEAKY:    y = neg ? leak : x;
            ACT_CLIP:     y = neg ? '0 : (over ? CLIP_MAX : x);
            default:      y = x;
        endcase
    end

endmodule

// File: rtl/activation_layer_seq.sv
// Time-multiplexed activation stage: snapshots a vector on act_go,
// runs it through LANES activation units over several beats, then
// pulses act_done and holds the result with act_valid.
// Ports: clk, reset (sync, active low), act_go, act_mode,
//        data_in_array, act_busy, act_done, act_valid, data_out_array.
module activation_layer_seq
    import nn_pkg::*;
#(
    parameter int               NEURON_NB  = 10,
    parameter int               WIDTH      = 32,
    parameter int               LANES      = 4,
    parameter int               LEAK_SHIFT = 3,
    parameter logic [WIDTH-1:0] CLIP_MAX   = WIDTH'(32'h0001_0000)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       act_go,
    input  logic [1:0]                 act_mode,
    input  logic [WIDTH*NEURON_NB-1:0] data_in_array,
    output logic                       act_busy,
    output logic                       act_done,
    output logic                       act_valid,
    output logic [WIDTH*NEURON_NB-1:0] data_out_array
);

    localparam int VW    = WIDTH * NEURON_NB;
    localparam int BEATS = ceil_div(NEURON_NB, LANES);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    act_state_e    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    act_mode_e     mode_q, mode_d;
    logic [VW-1:0] in_q, in_d;
    logic [VW-1:0] out_q, out_d;
    logic          valid_q, valid_d;

    logic [WIDTH-1:0] lane_x [LANES];
    logic [WIDTH-1:0] lane_y [LANES];

    // Lane k sees element beat*LANES+k; lanes past the end see zero
    always_comb begin
        int j;
        for (int k = 0; k < LANES; k++) begin
            j = int'(beat_q) * LANES + k;
            lane_x[k] = '0;
            if (j < NEURON_NB) begin
                lane_x[k] = in_q[j*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        activation_unit #(
            .WIDTH      (WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT),
            .CLIP_MAX   (CLIP_MAX)
        ) u_act (
            .x    (lane_x[g]),
            .mode (mode_q),
            .y    (lane_y[g])
        );
    end

    always_comb begin
        int j;
        state_d = state_q;
        beat_d  = beat_q;
        mode_d  = mode_q;
        in_d    = in_q;
        out_d   = out_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (act_go) begin
                    in_d    = data_in_array;
                    mode_d  = act_mode_e'(act_mode);
                    beat_d  = '0;
                    valid_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // gated lanes on the last beat leave their slots alone
                for (int k = 0; k < LANES; k++) begin
                    j = int'(beat_q) * LANES + k;
                    if (j < NEURON_NB) begin
                        out_d[j*WIDTH +: WIDTH] = lane_y[k];
                    end
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            mode_q  <= ACT_IDENTITY;
            in_q    <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            mode_q  <= mode_d;
            in_q    <= in_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign act_busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign act_done       = (state_q == ST_DONE);
    assign act_valid      = valid_q;
    assign data_out_array = out_q;

endmodule

// File: tb/tb_activation_layer_seq.sv
// Bench for activation_layer_seq: four builds (LANES 4,3,1,10) share
// stimulus; a per-build scoreboard is checked on every done pulse.
module tb_activation_layer_seq;

    localparam int N  = 10;
    localparam int W  = 32;
    localparam int VW = N * W;
    localparam int ND = 4;

    function automatic int lanes_of(input int g);
        case (g)
            0:       return 4;
            1:       return 3;
            2:       return 1;
            default: return 10;
        endcase
    endfunction

    function automatic int beats_of(input int g);
        return (N + lanes_of(g) - 1) / lanes_of(g);
    endfunction

    typedef struct {
        logic [VW-1:0] vec;
        int            done_cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [ND-1:0] go_v;
    logic [1:0]    mode;
    logic [VW-1:0] din;
    logic [ND-1:0] busy_w;
    logic [ND-1:0] done_w;
    logic [ND-1:0] valid_w;
    logic [VW-1:0] dout_w [ND];

    int   cyc;
    int   tot;
    int   bad;
    exp_t sb [ND][$];
    logic [ND-1:0] vchk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        activation_layer_seq #(
            .NEURON_NB  (N),
            .WIDTH      (W),
            .LANES      (lanes_of(g)),
            .LEAK_SHIFT (3),
            .CLIP_MAX   (32'h0001_0000)
        ) u_dut (
            .clk            (clk),
            .reset          (rst_n),
            .act_go         (go_v[g]),
            .act_mode       (mode),
            .data_in_array  (din),
            .act_busy       (busy_w[g]),
            .act_done       (done_w[g]),
            .act_valid      (valid_w[g]),
            .data_out_array (dout_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] act_ref(input logic [W-1:0] x,
                                             input logic [1:0] m);
        longint xs;
        longint ys;
        xs = longint'($signed(x));
        case (m)
            2'd0: ys = xs;
            2'd1: ys = (xs < 0) ? 0 : xs;
            2'd2: ys = (xs < 0) ? (xs - 7) / 8 : xs;
            default: ys = (xs < 0) ? 0 : ((xs > 65536) ? 65536 : xs);
        endcase
        return ys[W-1:0];
    endfunction

    function automatic logic [VW-1:0] vec_ref(input logic [VW-1:0] v,
                                              input logic [1:0] m);
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = act_ref(v[i*W +: W], m);
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < ND; g++) begin
            if (vchk[g]) begin
                vchk[g] = 1'b0;
                chk($sformatf("valid_after%0d", g), valid_w[g], 1'b1);
            end
            if (done_w[g]) begin
                if (sb[g].size() == 0) begin
                    chk($sformatf("spurious_done%0d", g), done_w[g], 1'b0);
                end else begin
                    e = sb[g].pop_front();
                    chk($sformatf("done_cyc%0d", g), cyc, e.done_cyc);
                    chk($sformatf("busy_done%0d", g), busy_w[g], 1'b1);
                    chk($sformatf("valid_done%0d", g), valid_w[g], 1'b0);
                    for (int i = 0; i < N; i++)
                        chk($sformatf("d%0d_e%0d", g, i),
                            dout_w[g][i*W +: W], e.vec[i*W +: W]);
                    vchk[g] = 1'b1;
                end
            end
        end
    end

    // go is high for `hold` edges; inputs are scrambled right after
    task automatic run_vec(input logic [1:0] m, input logic [VW-1:0] v,
                           input logic [ND-1:0] mask, input int hold);
        exp_t e;
        @(negedge clk);
        mode = m;
        din  = v;
        go_v = mask;
        for (int g = 0; g < ND; g++) begin
            if (mask[g]) begin
                e.vec      = vec_ref(v, m);
                e.done_cyc = cyc + 1 + beats_of(g);
                sb[g].push_back(e);
            end
        end
        repeat (hold) @(negedge clk);
        go_v = '0;
        din  = ~v;
        mode = ~m;
        repeat (14) @(negedge clk);
    endtask

    function automatic logic [VW-1:0] pack(input logic [W-1:0] a [N]);
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    initial begin
        logic [W-1:0] a [N];
        tot   = 0;
        bad   = 0;
        vchk  = '0;
        rst_n = 1'b0;
        go_v  = '0;
        mode  = 2'd0;
        din   = '0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("rst_busy%0d", g), busy_w[g], 1'b0);
            chk($sformatf("rst_done%0d", g), done_w[g], 1'b0);
            chk($sformatf("rst_valid%0d", g), valid_w[g], 1'b0);
            chk($sformatf("rst_dout%0d", g), 64'(|dout_w[g]), 64'd0);
        end
        rst_n = 1'b1;

        a = '{-32'sd5, 32'd0, 32'd7, -32'sd1, 32'd100, -32'sd100,
              32'h8000_0000, 32'd1, -32'sd2, 32'h7FFF_FFFF};
        run_vec(2'd1, pack(a), 4'hF, 1);

        a = '{-32'sd8, -32'sd1, -32'sd17, 32'd40, 32'h8000_0000,
              -32'sd9, 32'd0, 32'h7FFF_FFFF, -32'sd7, 32'd3};
        run_vec(2'd2, pack(a), 4'hF, 1);

        a = '{32'h2_0000, 32'h1_0000, 32'h0_FFFF, -32'sd3, 32'd0,
              32'h7FFF_FFFF, 32'h8000_0000, 32'h1_0001, 32'd1, -32'sd1};
        run_vec(2'd3, pack(a), 4'hF, 1);

        run_vec(2'd0, rnd_vec(), 4'hF, 1);

        // go held through RUN and the DONE cycle: one vector only
        run_vec(2'd1, rnd_vec(), 4'b0001, 5);

        for (int r = 0; r < 4; r++)
            run_vec(2'($urandom_range(3)), rnd_vec(), 4'hF, 1);

        // reset while the 4-lane build sits in beat 1
        @(negedge clk);
        mode = 2'd1;
        din  = rnd_vec();
        go_v = 4'b0001;
        begin
            exp_t e;
            e.vec      = vec_ref(din, mode);
            e.done_cyc = cyc + 4;
            sb[0].push_back(e);
        end
        @(negedge clk);
        go_v = '0;
        @(negedge clk);
        rst_n = 1'b0;
        sb[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy_w[0], 1'b0);
        chk("abort_done", done_w[0], 1'b0);
        for (int g = 0; g < ND; g++)
            chk($sformatf("abort_valid%0d", g), valid_w[g], 1'b0);
        repeat (14) @(negedge clk);

        run_vec(2'd2, rnd_vec(), 4'hF, 1);

        for (int g = 0; g < ND; g++)
            chk($sformatf("sb_drain%0d", g), sb[g].size(), 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
